// File: rtl/alu_iterative.sv
// Multi-cycle ADD/SUB/MUL/DIV unit: single-cycle add/sub, shift-add multiply, restoring divide.
// Optional overflow flag output alu_ovf is enabled by defining ALU_ITERATIVE_OVF_EN.
module alu_iterative #(
    parameter int unsigned REG_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          alu_operation,
    input  logic [REG_SIZE-1:0] alu_op1,
    input  logic [REG_SIZE-1:0] alu_op2,
    input  logic                alu_req,
    output logic                alu_done,
    output logic [REG_SIZE-1:0] alu_res,
`ifdef ALU_ITERATIVE_OVF_EN
    output logic                alu_busy,
    output logic                alu_ovf
`else
    output logic                alu_busy
`endif
);

    localparam int unsigned N    = REG_SIZE;
    localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StAddSub,
        StMul,
        StDiv,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic [2*N-1:0]    acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]      res_q, res_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
`ifdef ALU_ITERATIVE_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [N:0]        add_sum;
    logic [N:0]        sub_diff;
    logic [N:0]        mul_sum;
    logic [2*N-1:0]    mul_next;
    logic [N:0]        div_shift;
    logic [N:0]        div_trial;
    logic              div_ge;
    logic [2*N-1:0]    div_next;
    logic              last_step;

    assign add_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign sub_diff = {1'b0, a_q} - {1'b0, b_q};

    // Multiply: acc holds {partial product, remaining multiplier bits}; shift right each step.
    assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, a_q} : {(N+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[N-1:1]};

    // Divide: acc holds {remainder, dividend/quotient}; trial bit N set means the subtract went
    // negative, since the shifted remainder is always below 2*divisor.
    assign div_shift = acc_q[2*N-1:N-1];
    assign div_trial = div_shift - {1'b0, b_q};
    assign div_ge    = ~div_trial[N];
    assign div_next  = {(div_ge ? div_trial[N-1:0] : div_shift[N-1:0]), acc_q[N-2:0], div_ge};

    assign last_step = (cnt_q == CntW'(N - 1));

`ifndef ALU_ITERATIVE_OVF_EN
    logic unused_flags;
    assign unused_flags = ^{add_sum[N], sub_diff[N]};
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = 1'b0;
`ifdef ALU_ITERATIVE_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (alu_req) begin
                    op_d  = alu_operation;
                    a_d   = alu_op1;
                    b_d   = alu_op2;
                    cnt_d = '0;
                    acc_d = {{N{1'b0}}, (alu_operation == OpMul) ? alu_op2 : alu_op1};
                    case (alu_operation)
                        OpMul:   state_d = StMul;
                        OpDiv:   state_d = (alu_op2 != '0) ? StDiv : StAddSub;
                        default: state_d = StAddSub;
                    endcase
                end
            end

            StAddSub: begin
                state_d = StDone;
                done_d  = 1'b1;
                case (op_q)
                    OpAdd: begin
                        res_d = add_sum[N-1:0];
`ifdef ALU_ITERATIVE_OVF_EN
                        ovf_d = add_sum[N];
`endif
                    end
                    OpSub: begin
                        res_d = sub_diff[N-1:0];
`ifdef ALU_ITERATIVE_OVF_EN
                        ovf_d = sub_diff[N];
`endif
                    end
                    default: begin
                        // Only a zero-divisor DIV reaches here besides ADD/SUB.
                        res_d = {N{1'b1}};
`ifdef ALU_ITERATIVE_OVF_EN
                        ovf_d = 1'b1;
`endif
                    end
                endcase
            end

            StMul: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CntW'(1);
                if (last_step) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    res_d   = mul_next[N-1:0];
`ifdef ALU_ITERATIVE_OVF_EN
                    ovf_d   = (mul_next[2*N-1:N] != '0);
`endif
                end
            end

            StDiv: begin
                acc_d = div_next;
                cnt_d = cnt_q + CntW'(1);
                if (last_step) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    res_d   = div_next[N-1:0];
`ifdef ALU_ITERATIVE_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef ALU_ITERATIVE_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign alu_ovf = ovf_q;
`endif

    assign alu_done = done_q;
    assign alu_res  = res_q;
    assign alu_busy = busy_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative (REG_SIZE=8): vector table plus busy/done/reset sequences.
module tb_alu_iterative;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    logic       clk;
    logic       rst;
    logic [1:0] alu_operation;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic       alu_req;
    logic       alu_done;
    logic [7:0] alu_res;
    logic       alu_busy;
`ifdef ALU_ITERATIVE_OVF_EN
    logic       alu_ovf;
`endif

    int checks = 0;
    int errors = 0;

    alu_iterative #(.REG_SIZE(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_operation (alu_operation),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_req       (alu_req),
        .alu_done      (alu_done),
        .alu_res       (alu_res),
`ifdef ALU_ITERATIVE_OVF_EN
        .alu_busy      (alu_busy),
        .alu_ovf       (alu_ovf)
`else
        .alu_busy      (alu_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        int         lat;
        logic       ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        alu_operation = op;
        alu_op1       = a;
        alu_op2       = b;
        alu_req       = 1'b1;
        @(posedge clk);
        #1;
        alu_req = 1'b0;
    endtask

    // Returns edges until alu_done is seen, or -1 if the budget runs out.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (alu_done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;

        vecs[0]  = '{OpAdd, 8'd200, 8'd100, 8'd44,  1, 1'b1};
        vecs[1]  = '{OpSub, 8'd5,   8'd7,   8'd254, 1, 1'b1};
        vecs[2]  = '{OpSub, 8'd7,   8'd5,   8'd2,   1, 1'b0};
        vecs[3]  = '{OpMul, 8'd13,  8'd11,  8'd143, 8, 1'b0};
        vecs[4]  = '{OpMul, 8'd20,  8'd20,  8'd144, 8, 1'b1};
        vecs[5]  = '{OpDiv, 8'd200, 8'd7,   8'd28,  8, 1'b0};
        vecs[6]  = '{OpDiv, 8'd7,   8'd200, 8'd0,   8, 1'b0};
        vecs[7]  = '{OpDiv, 8'd255, 8'd1,   8'd255, 8, 1'b0};
        vecs[8]  = '{OpDiv, 8'd42,  8'd0,   8'd255, 1, 1'b1};
        vecs[9]  = '{OpAdd, 8'd255, 8'd1,   8'd0,   1, 1'b1};
        vecs[10] = '{OpMul, 8'd255, 8'd255, 8'd1,   8, 1'b1};
        vecs[11] = '{OpDiv, 8'd255, 8'd255, 8'd1,   8, 1'b0};
        vecs[12] = '{OpSub, 8'd0,   8'd0,   8'd0,   1, 1'b0};
        vecs[13] = '{OpMul, 8'd0,   8'd77,  8'd0,   8, 1'b0};

        rst           = 1'b1;
        alu_operation = 2'b00;
        alu_op1       = 8'd0;
        alu_op2       = 8'd0;
        alu_req       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_done", int'(alu_done), 0);
        check("reset_res",  int'(alu_res),  0);
        check("reset_busy", int'(alu_busy), 0);
`ifdef ALU_ITERATIVE_OVF_EN
        check("reset_ovf",  int'(alu_ovf),  0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            start(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), int'(alu_busy), 1);
            wait_done(lat);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_res", i), int'(alu_res), int'(vecs[i].res));
`ifdef ALU_ITERATIVE_OVF_EN
            check($sformatf("v%0d_ovf", i), int'(alu_ovf), int'(vecs[i].ovf));
`endif
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pulse", i), int'(alu_done), 0);
            check($sformatf("v%0d_hold", i), int'(alu_res), int'(vecs[i].res));
        end

        // Requests pulsed while busy must neither disturb nor queue.
        start(OpMul, 8'd13, 8'd11);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            alu_operation = OpAdd;
            alu_op1       = 8'd1;
            alu_op2       = 8'd1;
            alu_req       = 1'b1;
            @(posedge clk);
            #1;
            alu_req = 1'b0;
            check("busy_pulse_done", int'(alu_done), 0);
            check("busy_pulse_busy", int'(alu_busy), 1);
        end
        wait_done(lat);
        check("busy_lat", (lat < 0) ? -1 : lat + 3, 8);
        check("busy_res", int'(alu_res), 143);
        check("done_busy", int'(alu_busy), 1);
        // Request coinciding with DONE is dropped.
        alu_req = 1'b1;
        @(posedge clk);
        #1;
        alu_req = 1'b0;
        check("done_req_busy", int'(alu_busy), 0);
        check("done_req_done", int'(alu_done), 0);
        @(posedge clk);
        #1;
        check("done_req_idle", int'(alu_busy), 0);
        check("done_req_res",  int'(alu_res),  143);

        // Reset mid-multiply aborts with no completion.
        start(OpMul, 8'd13, 8'd11);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", int'(alu_busy), 0);
        check("abort_res",  int'(alu_res),  0);
        check("abort_done", int'(alu_done), 0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (alu_done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_idle", int'(alu_busy), 0);
        start(OpAdd, 8'd1, 8'd1);
        wait_done(lat);
        check("post_reset_lat", lat, 1);
        check("post_reset_res", int'(alu_res), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
